// File: rtl/stepper_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : stepper_pkg                                                      |
// | Brief   : Shared widths, FSM states and coil sequence for the stepper ctrl |
// | Revision: 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
package stepper_pkg;

    localparam int c_STEP_W_DEF = 16;
    localparam int c_POS_W_DEF  = 32;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_SETTLE = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    // Entry 0 is the rightmost literal; odd indices are the two-phase-on patterns.
    localparam logic [7:0][3:0] c_SEQ_TABLE = {
        4'b1001, 4'b0001, 4'b0011, 4'b0010,
        4'b0110, 4'b0100, 4'b1100, 4'b1000
    };

    function automatic logic [2:0] next_idx(input logic [2:0] idx,
                                            input logic       fwd,
                                            input logic       half);
        logic [2:0] w_idx;
        if (half) begin
            w_idx = fwd ? idx + 3'd1 : idx - 3'd1;
        end else begin
            w_idx = (fwd ? idx + 3'd2 : idx - 3'd2) | 3'd1;
        end
        return w_idx;
    endfunction

endpackage
`default_nettype wire

// File: rtl/stepper_motor_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : stepper_motor_ctrl_if                                            |
// | Brief   : Move-command valid/ready channel into the stepper controller     |
// | Revision: 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
interface stepper_motor_ctrl_if
    import stepper_pkg::*;
#(
    parameter int STEP_W = c_STEP_W_DEF
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_dir;
    logic              cmd_half;
    logic [STEP_W-1:0] cmd_steps;

    modport master (
        output cmd_valid,
        output cmd_dir,
        output cmd_half,
        output cmd_steps,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_dir,
        input  cmd_half,
        input  cmd_steps,
        output cmd_ready
    );
endinterface
`default_nettype wire

// File: rtl/step_tick_sync.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : step_tick_sync                                                   |
// | Brief   : Synchronizes the slow step clock and emits a 1-cycle rise tick   |
// | Revision: 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module step_tick_sync (
    input  wire logic fpga_clk,
    input  wire logic rst,
    input  wire logic i_step_clk,
    output logic      o_tick
);
    logic r_sync1;
    logic r_sync2;
    logic r_hist;
    logic r_tick;

    always_ff @(posedge fpga_clk or negedge rst) begin
        if (!rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_hist  <= 1'b0;
            r_tick  <= 1'b0;
        end else begin
            r_sync1 <= i_step_clk;
            r_sync2 <= r_sync1;
            r_hist  <= r_sync2;
            // Registered so the tick lands three cycles after the input rises.
            r_tick  <= r_sync2 & ~r_hist;
        end
    end

    assign o_tick = r_tick;
endmodule
`default_nettype wire

// File: rtl/stepper_motor_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : stepper_motor_ctrl                                               |
// | Brief   : Step sequencer driving four coils from synchronized step ticks   |
// | Revision: 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module stepper_motor_ctrl
    import stepper_pkg::*;
#(
    parameter int STEP_W       = c_STEP_W_DEF,
    parameter int POS_W        = c_POS_W_DEF,
    parameter int SETTLE_TICKS = 2,
    parameter int HOLD_TORQUE  = 1
) (
    input  wire logic               fpga_clk,
    input  wire logic               rst,
    input  wire logic               step_clk,
    stepper_motor_ctrl_if.slave     cmd,
    input  wire logic               abort,
    output logic [3:0]              coil,
    output logic                    busy,
    output logic                    done,
    output logic                    aborted,
    output logic signed [POS_W-1:0] position
);
    localparam int c_SET_W = (SETTLE_TICKS > 1) ? $clog2(SETTLE_TICKS + 1) : 1;

    state_t                   r_state;
    logic [2:0]               r_idx;
    logic [STEP_W-1:0]        r_rem;
    logic [c_SET_W-1:0]       r_settle;
    logic                     r_dir;
    logic                     r_half;
    logic                     r_abort_hist;
    logic signed [POS_W-1:0]  r_pos;
    logic [3:0]               r_coil;
    logic                     r_ready;
    logic                     r_busy;
    logic                     r_done;
    logic                     r_aborted;

    logic                     w_tick;
    logic [2:0]               w_idx_step;
    logic [3:0]               w_coil_idle;

    step_tick_sync u_tick (
        .fpga_clk   (fpga_clk),
        .rst        (rst),
        .i_step_clk (step_clk),
        .o_tick     (w_tick)
    );

    assign w_idx_step  = next_idx(r_idx, r_dir, r_half);
    assign w_coil_idle = (HOLD_TORQUE != 0) ? c_SEQ_TABLE[r_idx] : 4'b0000;

    always_ff @(posedge fpga_clk or negedge rst) begin
        if (!rst) begin
            r_state      <= ST_IDLE;
            r_idx        <= 3'd0;
            r_rem        <= '0;
            r_settle     <= '0;
            r_dir        <= 1'b0;
            r_half       <= 1'b0;
            r_abort_hist <= 1'b0;
            r_pos        <= '0;
            r_coil       <= 4'b0000;
            r_ready      <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_aborted    <= 1'b0;
        end else begin
            r_done    <= 1'b0;
            r_aborted <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (cmd.cmd_valid && r_ready) begin
                        r_dir        <= cmd.cmd_dir;
                        r_half       <= cmd.cmd_half;
                        r_rem        <= cmd.cmd_steps;
                        r_abort_hist <= 1'b0;
                        r_ready      <= 1'b0;
                        r_coil       <= c_SEQ_TABLE[r_idx];
                        if (cmd.cmd_steps == '0) begin
                            r_state <= ST_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= ST_RUN;
                            r_busy  <= 1'b1;
                        end
                    end else begin
                        r_ready <= 1'b1;
                        r_coil  <= w_coil_idle;
                    end
                end

                ST_RUN: begin
                    // Abort wins over a coincident tick: no step is taken that cycle.
                    if (w_tick && !abort) begin
                        r_idx  <= w_idx_step;
                        r_coil <= c_SEQ_TABLE[w_idx_step];
                        r_rem  <= r_rem - STEP_W'(1);
                        r_pos  <= r_dir ? r_pos + POS_W'(1) : r_pos - POS_W'(1);
                    end
                    if (abort || (w_tick && r_rem == STEP_W'(1))) begin
                        if (abort) begin
                            r_abort_hist <= 1'b1;
                        end
                        if (SETTLE_TICKS == 0) begin
                            r_state   <= ST_DONE;
                            r_busy    <= 1'b0;
                            r_done    <= 1'b1;
                            r_aborted <= abort;
                        end else begin
                            r_state  <= ST_SETTLE;
                            r_settle <= c_SET_W'(SETTLE_TICKS);
                        end
                    end
                end

                ST_SETTLE: begin
                    if (abort || (w_tick && r_settle == c_SET_W'(1))) begin
                        r_state   <= ST_DONE;
                        r_busy    <= 1'b0;
                        r_done    <= 1'b1;
                        r_aborted <= abort | r_abort_hist;
                        if (abort) begin
                            r_abort_hist <= 1'b1;
                        end
                    end else if (w_tick) begin
                        r_settle <= r_settle - c_SET_W'(1);
                    end
                end

                ST_DONE: begin
                    r_state <= ST_IDLE;
                    r_ready <= 1'b1;
                    r_coil  <= w_coil_idle;
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign cmd.cmd_ready = r_ready;
    assign coil          = r_coil;
    assign busy          = r_busy;
    assign done          = r_done;
    assign aborted       = r_aborted;
    assign position      = r_pos;
endmodule
`default_nettype wire

// File: tb/tb_stepper_motor_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_stepper_motor_ctrl                                            |
// | Brief   : Vector table, directed corners and random moves vs move model    |
// | Revision: 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module tb_stepper_motor_ctrl;
    localparam int SETTLE = 2;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               step_clk = 1'b0;
    logic               abort = 1'b0;
    logic [3:0]         coil;
    logic               busy;
    logic               done;
    logic               aborted;
    logic signed [31:0] position;

    stepper_motor_ctrl_if #(.STEP_W(16)) cmd_if ();

    stepper_motor_ctrl #(
        .STEP_W       (16),
        .POS_W        (32),
        .SETTLE_TICKS (SETTLE),
        .HOLD_TORQUE  (1)
    ) dut (
        .fpga_clk (clk),
        .rst      (rst_n),
        .step_clk (step_clk),
        .cmd      (cmd_if),
        .abort    (abort),
        .coil     (coil),
        .busy     (busy),
        .done     (done),
        .aborted  (aborted),
        .position (position)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    logic [3:0] seq [8] = '{4'b1000, 4'b1100, 4'b0100, 4'b0110,
                            4'b0010, 4'b0011, 4'b0001, 4'b1001};
    int                 m_idx = 0;
    logic signed [31:0] m_pos = 0;

    // Observation of the coil pattern stream and done pulses.
    logic [3:0] obs_q [$];
    logic [3:0] prev_coil = 4'b0000;
    logic       prev_done = 1'b0;
    int         done_cnt  = 0;
    logic       last_aborted = 1'b0;

    always @(posedge clk) begin
        #2;
        if (rst_n) begin
            if (coil != prev_coil) obs_q.push_back(coil);
            if (done) begin
                done_cnt++;
                last_aborted = aborted;
            end
            if (done && prev_done) begin
                n_checks++;
                n_errors++;
                $display("FAIL done_width: done high on consecutive cycles, required one-cycle pulse");
            end
        end
        prev_coil = coil;
        prev_done = done;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    function automatic int step_of(input int idx, input bit fwd, input bit half);
        if (half) return (idx + (fwd ? 1 : 7)) % 8;
        return ((idx + (fwd ? 2 : 6)) % 8) | 1;
    endfunction

    task automatic wait_ready();
        int n = 0;
        while (cmd_if.cmd_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (cmd_if.cmd_ready !== 1'b1) begin
            n_checks++;
            n_errors++;
            $display("FAIL ready_timeout: cmd_ready=%b, required 1 within 20 cycles", cmd_if.cmd_ready);
        end
    endtask

    task automatic issue_cmd(input bit fwd, input bit half, input int steps);
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd_dir   = fwd;
        cmd_if.cmd_half  = half;
        cmd_if.cmd_steps = 16'(steps);
        @(negedge clk);
        cmd_if.cmd_valid = 1'b0;
    endtask

    // One step_clk period of 12 cycles; abort is raised in the cycle the tick is seen.
    task automatic step_pulse(input bit with_abort);
        step_clk = 1'b1;
        repeat (3) @(negedge clk);
        abort = with_abort;
        @(negedge clk);
        abort = 1'b0;
        repeat (2) @(negedge clk);
        step_clk = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    task automatic run_move(input bit fwd, input bit half, input int steps, input int abort_tick);
        int   exec;
        bit   exp_ab;
        int   npulses;
        logic [3:0] exp_q [$];
        exp_ab  = (steps != 0) && (abort_tick != 0) && (abort_tick <= steps + SETTLE);
        exec    = (exp_ab && abort_tick <= steps) ? abort_tick - 1 : steps;
        npulses = (steps == 0) ? 0 :
                  !exp_ab ? steps + SETTLE :
                  (abort_tick <= steps) ? abort_tick + SETTLE : abort_tick;
        for (int k = 0; k < exec; k++) begin
            m_idx = step_of(m_idx, fwd, half);
            exp_q.push_back(seq[m_idx]);
        end
        m_pos = fwd ? m_pos + exec : m_pos - exec;

        wait_ready();
        obs_q.delete();
        done_cnt = 0;
        last_aborted = 1'b0;
        issue_cmd(fwd, half, steps);
        check("busy_after_accept", busy, (steps != 0));
        for (int p = 1; p <= npulses; p++) step_pulse(p == abort_tick);
        repeat (3) @(negedge clk);

        check("done_count", done_cnt, 1);
        check("done_aborted", last_aborted, exp_ab);
        check("coil_change_count", obs_q.size(), exp_q.size());
        for (int k = 0; k < exp_q.size() && k < obs_q.size(); k++)
            check("coil_step", obs_q[k], exp_q[k]);
        check("position", position, m_pos);
        check("busy_idle", busy, 1'b0);
        check("ready_idle", cmd_if.cmd_ready, 1'b1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        m_idx = 0;
        m_pos = 0;
    endtask

    typedef struct {
        bit         fwd;
        bit         half;
        int         steps;
        int         abort_tick;
        logic [3:0] exp_coil;
        int         exp_pos;
        bit         exp_ab;
    } vec_t;

    vec_t vecs [7];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt_snap;
        vecs[0] = '{1'b1, 1'b1, 3, 0, 4'b0110,  3, 1'b0};
        vecs[1] = '{1'b0, 1'b0, 2, 0, 4'b1001,  1, 1'b0};
        vecs[2] = '{1'b1, 1'b1, 0, 0, 4'b1001,  1, 1'b0};
        vecs[3] = '{1'b1, 1'b0, 5, 2, 4'b1100,  2, 1'b1};
        vecs[4] = '{1'b0, 1'b1, 4, 5, 4'b0011, -2, 1'b1};
        vecs[5] = '{1'b1, 1'b1, 2, 0, 4'b1001,  0, 1'b0};
        vecs[6] = '{1'b1, 1'b0, 1, 1, 4'b1001,  0, 1'b1};

        cmd_if.cmd_valid = 1'b0;
        cmd_if.cmd_dir   = 1'b0;
        cmd_if.cmd_half  = 1'b0;
        cmd_if.cmd_steps = '0;

        // Reset values, then idle with holding torque.
        repeat (3) @(negedge clk);
        check("rst_coil", coil, 4'b0000);
        check("rst_ready", cmd_if.cmd_ready, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_pos", position, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_coil", coil, 4'b1000);
        check("idle_ready", cmd_if.cmd_ready, 1'b1);
        check("idle_busy", busy, 1'b0);

        // Reverse full-step from idx 0 with tick latency and done timing.
        done_cnt = 0;
        issue_cmd(1'b0, 1'b0, 2);
        check("rf_busy", busy, 1'b1);
        check("rf_ready", cmd_if.cmd_ready, 1'b0);
        step_clk = 1'b1;
        repeat (3) @(negedge clk);
        check("rf_coil_before_tick", coil, 4'b1000);
        @(negedge clk);
        check("rf_coil_after_tick", coil, 4'b1001);
        repeat (2) @(negedge clk);
        step_clk = 1'b0;
        repeat (6) @(negedge clk);
        step_pulse(1'b0);
        check("rf_coil2", coil, 4'b0011);
        check("rf_pos", position, -2);
        step_pulse(1'b0);
        check("rf_no_done_yet", done_cnt, 0);
        check("rf_busy_settle", busy, 1'b1);
        step_clk = 1'b1;
        repeat (3) @(negedge clk);
        check("rf_done_early", done, 1'b0);
        @(negedge clk);
        check("rf_done", done, 1'b1);
        check("rf_aborted", aborted, 1'b0);
        check("rf_busy_done", busy, 1'b0);
        check("rf_ready_done", cmd_if.cmd_ready, 1'b0);
        @(negedge clk);
        check("rf_done_drop", done, 1'b0);
        check("rf_ready_back", cmd_if.cmd_ready, 1'b1);
        step_clk = 1'b0;
        repeat (6) @(negedge clk);

        // Vector table from a clean reset.
        do_reset();
        for (int i = 0; i < 7; i++) begin
            run_move(vecs[i].fwd, vecs[i].half, vecs[i].steps, vecs[i].abort_tick);
            check("tbl_coil", coil, vecs[i].exp_coil);
            check("tbl_pos", position, vecs[i].exp_pos);
            check("tbl_aborted", last_aborted, vecs[i].exp_ab);
        end

        // Zero-step command: done the cycle after accept, coils untouched.
        wait_ready();
        issue_cmd(1'b1, 1'b1, 0);
        check("zero_done", done, 1'b1);
        check("zero_aborted", aborted, 1'b0);
        check("zero_busy", busy, 1'b0);
        check("zero_coil", coil, seq[m_idx]);
        @(negedge clk);
        check("zero_done_drop", done, 1'b0);
        check("zero_ready", cmd_if.cmd_ready, 1'b1);

        // Abort while idle is ignored.
        done_cnt = 0;
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        repeat (3) @(negedge clk);
        check("idle_abort_done", done_cnt, 0);
        check("idle_abort_ready", cmd_if.cmd_ready, 1'b1);

        // Reset in the middle of a move.
        do_reset();
        wait_ready();
        issue_cmd(1'b1, 1'b1, 5);
        step_pulse(1'b0);
        step_pulse(1'b0);
        check("mid_pos_before", position, 2);
        cnt_snap = done_cnt;
        rst_n = 1'b0;
        #1;
        check("mid_rst_coil", coil, 4'b0000);
        check("mid_rst_pos", position, 0);
        check("mid_rst_busy", busy, 1'b0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("mid_rst_no_done", done_cnt, cnt_snap);
        m_idx = 0;
        m_pos = 0;
        run_move(1'b1, 1'b1, 1, 0);
        check("post_rst_coil", coil, 4'b1100);

        // Random moves against the move model.
        for (int r = 0; r < 20; r++) begin
            bit fwd;
            bit half;
            int steps;
            int ab;
            fwd   = 1'($urandom % 2);
            half  = 1'($urandom % 2);
            steps = int'($urandom_range(0, 6));
            ab    = (steps != 0 && ($urandom % 3) == 0) ? int'($urandom_range(1, steps + SETTLE)) : 0;
            run_move(fwd, half, steps, ab);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/stepper_motor_ctrl.md
# stepper_motor_ctrl

Stepper-motor sequencer that consumes the 100 Hz stepping-motor clock produced by the clock-divider stage and drives the four coil outputs of a unipolar/bipolar driver. Runs entirely in the fpga_clk domain: the 100 Hz clock is treated as a data input, synchronized, and edge-detected into a one-cycle step tick. Accepts move commands (direction, step count, full/half-step mode) over a valid/ready handshake, reports busy/done, and tracks absolute position.

## Interface
- STEP_W, 16, width of cmd_steps and of the internal remaining-step counter
- POS_W, 32, width of the signed position counter
- SETTLE_TICKS, 2, step ticks to wait after the last step before done (0 allowed)
- HOLD_TORQUE, 1, 1 = coils stay energized in IDLE, 0 = coils driven 4'b0000 in IDLE
- fpga_clk  in  1  system clock (100 MHz)
- rst  in  1  asynchronous, active-low reset
- step_clk  in  1  100 Hz stepping clock from the clock divider
- cmd_valid  in  1  command present
- cmd_ready  out  1  block can accept a command
- cmd_dir  in  1  1 = forward (+), 0 = reverse (−)
- cmd_half  in  1  1 = half-step, 0 = full-step (two-phase-on)
- cmd_steps  in  STEP_W  number of steps to execute
- abort  in  1  terminate current move
- coil  out  4  coil drive {A, B, A', B'} pattern
- busy  out  1  high in RUN and SETTLE
- done  out  1  one-cycle pulse at end of move
- aborted  out  1  valid with done: move was aborted
- position  out  POS_W  signed step count since reset

## Operation
- Sequence table, 8 entries, index idx[2:0]: 1000, 1100, 0100, 0110, 0010, 0011, 0001, 1001.
- Half-step: idx ± 1 mod 8 per step. Full-step: forward idx_next = ((idx+2) mod 8) | 1, reverse idx_next = ((idx−2) mod 8) | 1 (two-phase entries only).
- coil = table[idx] except in IDLE with HOLD_TORQUE=0 (then 4'b0000).
- States IDLE, RUN, SETTLE, DONE.
- IDLE: cmd_ready=1. On cmd_valid && cmd_ready latch dir/half/steps; steps=0 → DONE, else → RUN. A tick in the accept cycle is ignored.
- RUN: on each tick: update idx, remaining −1, position ±1 (one count per executed step, either mode). When remaining becomes 0 → SETTLE (settle counter = SETTLE_TICKS) or → DONE if SETTLE_TICKS=0.
- SETTLE: each tick decrements settle counter; at 0 → DONE.
- DONE: done=1 for one cycle, aborted reflects abort history, → IDLE.
- abort in RUN → SETTLE (or DONE if SETTLE_TICKS=0), aborted flag set; abort beats a same-cycle tick (no step taken). abort in SETTLE → DONE immediately, aborted set. abort in IDLE/DONE ignored.
- position wraps modulo 2^POS_W, no saturation.

## Timing
- Reset: coil = 4'b0000, idx=0, position=0, state IDLE, cmd_ready=0 during reset then 1, busy=0, done=0, aborted=0, sync flops 0.
- Tick = rising edge of step_clk after 2-flop synchronizer plus history flop; tick asserts 3 fpga_clk cycles after step_clk rises, width exactly 1 cycle.
- coil/position update registered: 1 cycle after tick.
- busy rises the cycle after accept; done pulses the cycle after final transition; cmd_ready returns 1 the cycle after done.
- Reset mid-move: immediate return to reset values, no done pulse.

## Structure
- Package stepper_pkg: state enum, 8-entry sequence table constant, default widths.
- Sub-module step_tick_sync: synchronizer + rising-edge detector producing tick.

## Test plan
- Reset release, HOLD_TORQUE=1, no command -> coil=1000, position=0, cmd_ready=1, busy=0.
- Forward half-step, steps=3 -> coil 1100, 0100, 0110 on successive ticks; position=3; done pulse SETTLE_TICKS (2) ticks after last step.
- Reverse full-step from idx=0, steps=2 -> coil 1001 then 0011... (idx 7, 5); position=−2.
- steps=0 -> done within 2 cycles of accept, no coil change, aborted=0.
- abort asserted on same cycle as 2nd tick of 5-step move -> only 1 step executed, position=1, done with aborted=1.
- Reset asserted mid-RUN -> coil=0000, position=0, no done pulse; new command accepted afterward.
